// File: rtl/msk_timing_ctrl.sv
// msk_timing_ctrl: symbol-timing controller for the MSK demodulator.
// Measures where phase-difference sign transitions fall inside the symbol,
// acquires an initial midpoint_adj, then tracks it one sample at a time.
module msk_timing_ctrl #(
  parameter int SAMPLES_PER_SYM = 80,
  parameter int ACQ_SYMS        = 64,
  parameter int TRK_SYMS        = 16,
  parameter int ADJ_MAX         = 20,
  parameter int DEADBAND        = 1,
  parameter int MIN_TRANS       = 8,
  parameter int LOSS_LIMIT      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               phase_valid,
  input  logic signed [31:0] phase_diff,
  input  logic               sym_start,
  output logic signed [31:0] midpoint_adj,
  output logic               adj_update,
  output logic               locked,
  output logic [1:0]         state
);
  localparam int PW = $clog2(SAMPLES_PER_SYM);
  localparam int HALF = SAMPLES_PER_SYM / 2;
  localparam logic signed [31:0] ADJ_HI = ADJ_MAX;
  localparam logic signed [31:0] ADJ_LO = -ADJ_MAX;
  localparam logic signed [31:0] DBAND  = DEADBAND;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, CALC = 2'd2, TRACK = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               s_prev_q, s_prev_d;
  logic               armed_q, armed_d;
  logic               from_trk_q, from_trk_d;
  logic [15:0]        sym_cnt_q, sym_cnt_d;
  logic signed [31:0] err_sum_q, err_sum_d;
  logic [31:0]        trans_cnt_q, trans_cnt_d;
  logic [31:0]        div_rem_q, div_rem_d;
  logic [31:0]        div_quo_q, div_quo_d;
  logic [5:0]         div_cnt_q, div_cnt_d;
  logic [7:0]         miss_q, miss_d;
  logic signed [31:0] adj_q, adj_d;
  logic               adj_update_q, adj_update_d;
  logic               locked_q, locked_d;

  logic [PW-1:0]      idx;
  logic signed [31:0] err;
  logic               s;
  logic [15:0]        win_last;
  logic [32:0]        rem_sh;
  logic signed [31:0] avg;
  logic               est_valid;

  function automatic logic signed [31:0] clamp_adj(input logic signed [31:0] v);
    if (v > ADJ_HI) return ADJ_HI;
    if (v < ADJ_LO) return ADJ_LO;
    return v;
  endfunction

  // Per-sample measurement: sample index, signed timing error, sign bit, divider helpers
  always_comb begin
    if (sym_start || pos_q == PW'(SAMPLES_PER_SYM - 1)) idx = '0;
    else idx = pos_q + 1'b1;
    err = $signed({{(32-PW){1'b0}}, idx});
    if (idx >= PW'(HALF)) err = err - SAMPLES_PER_SYM;
    s         = phase_diff > 32'sd0;
    win_last  = (state_q == TRACK) ? 16'(TRK_SYMS - 1) : 16'(ACQ_SYMS - 1);
    rem_sh    = {div_rem_q, div_quo_q[31]};
    est_valid = trans_cnt_q >= 32'(MIN_TRANS);
    avg       = err_sum_q[31] ? -$signed(div_quo_q) : $signed(div_quo_q);
  end

  // Next-state: window accumulation, serial divide, acquire/track decisions
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    s_prev_d     = s_prev_q;
    armed_d      = armed_q;
    from_trk_d   = from_trk_q;
    sym_cnt_d    = sym_cnt_q;
    err_sum_d    = err_sum_q;
    trans_cnt_d  = trans_cnt_q;
    div_rem_d    = div_rem_q;
    div_quo_d    = div_quo_q;
    div_cnt_d    = div_cnt_q;
    miss_d       = miss_q;
    adj_d        = adj_q;
    adj_update_d = 1'b0;
    locked_d     = locked_q;

    if (phase_valid) pos_d = idx;

    case (state_q)
      IDLE: if (enable) state_d = ACQUIRE;
      ACQUIRE, TRACK: begin
        if (phase_valid) begin
          if (!armed_q) begin
            // arming sample only primes the sign history
            if (sym_start) begin
              armed_d     = 1'b1;
              sym_cnt_d   = '0;
              s_prev_d    = s;
              err_sum_d   = '0;
              trans_cnt_d = '0;
            end
          end else if (sym_start && sym_cnt_q == win_last) begin
            // closing sample: any transition here is left out of the estimate
            state_d    = CALC;
            from_trk_d = (state_q == TRACK);
            div_rem_d  = '0;
            div_quo_d  = err_sum_q[31] ? 32'(-err_sum_q) : 32'(err_sum_q);
            div_cnt_d  = '0;
          end else begin
            if (sym_start) sym_cnt_d = sym_cnt_q + 16'd1;
            if (s != s_prev_q) begin
              err_sum_d   = err_sum_q + err;
              trans_cnt_d = trans_cnt_q + 32'd1;
            end
            s_prev_d = s;
          end
        end
      end
      CALC: begin
        if (est_valid && div_cnt_q != 6'd32) begin
          // one restoring-divide step of |err_sum| / trans_cnt
          if (rem_sh >= {1'b0, trans_cnt_q}) begin
            div_rem_d = 32'(rem_sh - {1'b0, trans_cnt_q});
            div_quo_d = {div_quo_q[30:0], 1'b1};
          end else begin
            div_rem_d = rem_sh[31:0];
            div_quo_d = {div_quo_q[30:0], 1'b0};
          end
          div_cnt_d = div_cnt_q + 6'd1;
        end else begin
          armed_d     = 1'b0;
          err_sum_d   = '0;
          trans_cnt_d = '0;
          if (!from_trk_q) begin
            if (est_valid) begin
              adj_d        = clamp_adj(avg);
              adj_update_d = 1'b1;
              locked_d     = 1'b1;
              miss_d       = '0;
              state_d      = TRACK;
            end else begin
              state_d = ACQUIRE;
            end
          end else if (est_valid) begin
            miss_d  = '0;
            state_d = TRACK;
            if (avg - adj_q > DBAND) adj_d = clamp_adj(adj_q + 32'sd1);
            else if (adj_q - avg > DBAND) adj_d = clamp_adj(adj_q - 32'sd1);
            adj_update_d = (adj_d != adj_q);
          end else if (miss_q == 8'(LOSS_LIMIT - 1)) begin
            locked_d = 1'b0;
            miss_d   = '0;
            state_d  = ACQUIRE;
          end else begin
            miss_d  = miss_q + 8'd1;
            state_d = TRACK;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // disable wins over everything; the applied offset is kept
    if (!enable) begin
      state_d      = IDLE;
      armed_d      = 1'b0;
      err_sum_d    = '0;
      trans_cnt_d  = '0;
      div_rem_d    = '0;
      div_quo_d    = '0;
      div_cnt_d    = '0;
      miss_d       = '0;
      locked_d     = 1'b0;
      adj_d        = adj_q;
      adj_update_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      s_prev_q     <= 1'b0;
      armed_q      <= 1'b0;
      from_trk_q   <= 1'b0;
      sym_cnt_q    <= '0;
      err_sum_q    <= '0;
      trans_cnt_q  <= '0;
      div_rem_q    <= '0;
      div_quo_q    <= '0;
      div_cnt_q    <= '0;
      miss_q       <= '0;
      adj_q        <= '0;
      adj_update_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      s_prev_q     <= s_prev_d;
      armed_q      <= armed_d;
      from_trk_q   <= from_trk_d;
      sym_cnt_q    <= sym_cnt_d;
      err_sum_q    <= err_sum_d;
      trans_cnt_q  <= trans_cnt_d;
      div_rem_q    <= div_rem_d;
      div_quo_q    <= div_quo_d;
      div_cnt_q    <= div_cnt_d;
      miss_q       <= miss_d;
      adj_q        <= adj_d;
      adj_update_q <= adj_update_d;
      locked_q     <= locked_d;
    end
  end

  assign midpoint_adj = adj_q;
  assign adj_update   = adj_update_q;
  assign locked       = locked_q;
  assign state        = state_q;
endmodule
